// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR MAC read engine.
package fir_pkg;

   localparam int unsigned BLK_W   = 5;
   localparam int unsigned BADDR_W = 9;
   localparam int unsigned MEM_AW  = 14;
   localparam int unsigned DW      = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } fir_mac_state_t;

endpackage

// File: rtl/fir_coef_rf.sv
// NTAPS x DW coefficient register file: one synchronous write port and
// one combinational read port.
module fir_coef_rf
   import fir_pkg::*;
#(
   parameter int unsigned NTAPS = 16,
   parameter int unsigned DW    = fir_pkg::DW
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [4:0]                wr_addr,
   input  logic [DW-1:0]             wr_data,
   input  logic [$clog2(NTAPS)-1:0]  rd_idx,
   output logic [DW-1:0]             rd_data_c
);

   localparam int unsigned IW = $clog2(NTAPS);

   logic [DW-1:0] coef_q [NTAPS];
   logic [DW-1:0] coef_d [NTAPS];

   // Out-of-range tap indices must not alias onto a real tap.
   always_comb begin
      coef_d = coef_q;
      if (wr_en && (32'(wr_addr) < NTAPS)) begin
         coef_d[wr_addr[IW-1:0]] = wr_data;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         coef_q <= '{default: '0};
      end else begin
         coef_q <= coef_d;
      end
   end

   assign rd_data_c = coef_q[rd_idx];

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR MAC engine: walks NTAPS samples newest-first out of one fir_imem block,
// multiply-accumulates against the local coefficient file, and hands off y.
module fir_mac_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned NTAPS = 16,
   parameter int unsigned DW    = fir_pkg::DW,
   parameter int unsigned ACCW  = 40
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                start,
   input  logic [BLK_W-1:0]    blk,
   input  logic [BADDR_W-1:0]  head,
   input  logic                coef_we,
   input  logic [4:0]          coef_addr,
   input  logic [DW-1:0]       coef_data,
   output logic                mem_CEN,
   output logic                mem_WEN,
   output logic [MEM_AW-1:0]   mem_A,
   input  logic [DW-1:0]       mem_Q,
   output logic                busy,
   output logic [ACCW-1:0]     y,
   output logic                y_valid,
   input  logic                y_ready
);

   localparam int unsigned IW = $clog2(NTAPS);

   fir_mac_state_t       state_q, state_d;
   logic [BLK_W-1:0]     blk_q, blk_d;
   logic [BADDR_W-1:0]   head_q, head_d;
   logic [IW-1:0]        k_q, k_d;
   logic [IW-1:0]        kp_q, kp_d;
   logic                 v_q, v_d;
   logic                 cen_q, cen_d;
   logic [MEM_AW-1:0]    a_q, a_d;
   logic [ACCW-1:0]      acc_q, acc_d;
   logic                 busy_q, busy_d;
   logic                 y_valid_q, y_valid_d;

   logic                 coef_wr_en_c;
   logic [DW-1:0]        coef_rd_c;
   logic signed [2*DW-1:0] prod_c;
   logic [ACCW-1:0]      prod_ext_c;

   assign coef_wr_en_c = coef_we && (state_q == IDLE);

   // Read port indexed by the delayed tap index so the coefficient lines up with mem_Q.
   fir_coef_rf #(
      .NTAPS (NTAPS),
      .DW    (DW)
   ) u_coef_rf (
      .CLK       (CLK),
      .reset     (reset),
      .wr_en     (coef_wr_en_c),
      .wr_addr   (coef_addr),
      .wr_data   (coef_data),
      .rd_idx    (kp_q),
      .rd_data_c (coef_rd_c)
   );

   assign prod_c     = $signed(mem_Q) * $signed(coef_rd_c);
   assign prod_ext_c = ACCW'(prod_c);

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      head_d  = head_q;
      k_d     = k_q;
      kp_d    = k_q;
      v_d     = ~cen_q;
      cen_d   = cen_q;
      a_d     = a_q;
      acc_d   = acc_q;

      // v_q marks a cycle where mem_Q carries a tap issued two edges back.
      if (v_q) begin
         acc_d = acc_q + prod_ext_c;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               blk_d   = blk;
               head_d  = head;
               k_d     = '0;
               acc_d   = '0;
               cen_d   = 1'b0;
               a_d     = {blk, head};
               state_d = RUN;
            end
         end
         RUN: begin
            if (k_q == IW'(NTAPS - 1)) begin
               cen_d   = 1'b1;
               state_d = DRAIN;
            end else begin
               k_d = k_q + 1'b1;
               a_d = {blk_q, head_q - BADDR_W'(k_d)};
            end
         end
         DRAIN: begin
            state_d = OUT;
         end
         OUT: begin
            if (y_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d    = (state_d != IDLE);
      y_valid_d = (state_d == OUT);
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         blk_q     <= '0;
         head_q    <= '0;
         k_q       <= '0;
         kp_q      <= '0;
         v_q       <= 1'b0;
         cen_q     <= 1'b1;
         a_q       <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         head_q    <= head_d;
         k_q       <= k_d;
         kp_q      <= kp_d;
         v_q       <= v_d;
         cen_q     <= cen_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign mem_CEN = cen_q;
   assign mem_WEN = 1'b1;
   assign mem_A   = a_q;
   assign busy    = busy_q;
   assign y_valid = y_valid_q;
   assign y       = acc_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed bench for fir_mac_ctrl with a 1-cycle-latency fir_imem model.
module tb_fir_mac_ctrl;

   localparam int unsigned NTAPS = 16;
   localparam int unsigned DW    = 16;
   localparam int unsigned ACCW  = 40;

   logic            CLK = 1'b0;
   logic            reset;
   logic            start;
   logic [4:0]      blk;
   logic [8:0]      head;
   logic            coef_we;
   logic [4:0]      coef_addr;
   logic [DW-1:0]   coef_data;
   logic            mem_CEN;
   logic            mem_WEN;
   logic [13:0]     mem_A;
   logic [DW-1:0]   mem_Q;
   logic            busy;
   logic [ACCW-1:0] y;
   logic            y_valid;
   logic            y_ready;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem [16384];

   always #5 CLK = ~CLK;

   fir_mac_ctrl #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .ACCW  (ACCW)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .start     (start),
      .blk       (blk),
      .head      (head),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .mem_CEN   (mem_CEN),
      .mem_WEN   (mem_WEN),
      .mem_A     (mem_A),
      .mem_Q     (mem_Q),
      .busy      (busy),
      .y         (y),
      .y_valid   (y_valid),
      .y_ready   (y_ready)
   );

   always @(posedge CLK) begin
      if (!mem_CEN) mem_Q <= mem[mem_A];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_coef(input logic [4:0] addr, input logic [DW-1:0] data);
      coef_we   = 1'b1;
      coef_addr = addr;
      coef_data = data;
      @(negedge CLK);
      coef_we   = 1'b0;
   endtask

   // One full run; we_at >= 0 pulses a coefficient write during that RUN cycle.
   task automatic run_check(input string tag, input logic [4:0] b, input logic [8:0] h,
                            input logic [ACCW-1:0] ey, input int we_at);
      start = 1'b1;
      blk   = b;
      head  = h;
      @(negedge CLK);
      start = 1'b0;
      blk   = '0;
      head  = '0;
      coef_addr = 5'd0;
      coef_data = 16'd7;
      for (int k = 0; k < int'(NTAPS); k++) begin
         check({tag, "_cen_addr"}, 64'({mem_CEN, mem_A}), 64'({1'b0, b, h - 9'(k)}));
         coef_we = (k == we_at);
         @(negedge CLK);
      end
      coef_we = 1'b0;
      check({tag, "_drain"}, 64'({busy, y_valid, mem_CEN}), 64'(3'b101));
      @(negedge CLK);
      check({tag, "_valid"}, 64'({busy, y_valid}), 64'(2'b11));
      check({tag, "_y"}, 64'(y), 64'(ey));
      if (y_ready) begin
         @(negedge CLK);
         check({tag, "_idle"}, 64'({busy, y_valid, mem_CEN}), 64'(3'b001));
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int seen;
      reset     = 1'b1;
      start     = 1'b0;
      blk       = '0;
      head      = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      y_ready   = 1'b1;
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      for (int i = 0; i < 16; i++) mem[{5'd0, 9'(i)}] = 16'(30 + 4 * i);
      for (int a = 0; a < 512; a++) mem[{5'd5, 9'(a)}] = 16'(a);
      for (int a = 0; a < 512; a++) mem[{5'd1, 9'(a)}] = 16'(3 * a + 1);
      mem[{5'd1, 9'd100}] = 16'h7FFF;

      repeat (2) @(negedge CLK);
      check("rst_flags", 64'({busy, y_valid, mem_CEN, mem_WEN}), 64'(4'b0011));
      check("rst_y", 64'(y), 64'd0);
      check("rst_addr", 64'(mem_A), 64'd0);
      reset = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 16; i++) load_coef(5'(i), 16'd1);
      run_check("basic", 5'd0, 9'd15, 40'd960, -1);
      run_check("wrap", 5'd5, 9'd3, 40'd6072, -1);

      // Write attempt during RUN must not land.
      run_check("busy_we", 5'd0, 9'd15, 40'd960, 0);
      run_check("readback", 5'd0, 9'd15, 40'd960, -1);

      // Backpressure: hold off the consumer while start is pulsed.
      y_ready = 1'b0;
      run_check("bp", 5'd0, 9'd15, 40'd960, -1);
      for (int c = 0; c < 5; c++) begin
         start = 1'b1;
         blk   = 5'd5;
         head  = 9'd3;
         @(negedge CLK);
         check("bp_hold", 64'({busy, y_valid, mem_CEN}), 64'(3'b111));
         check("bp_y", 64'(y), 64'd960);
      end
      start   = 1'b0;
      y_ready = 1'b1;
      @(negedge CLK);
      check("bp_xfer", 64'({busy, y_valid, mem_CEN}), 64'(3'b001));
      @(negedge CLK);
      check("bp_no_restart", 64'({busy, y_valid, mem_CEN}), 64'(3'b001));

      // Signed extremes; addr 16 lies outside the tap range.
      load_coef(5'd0, 16'h8000);
      for (int i = 1; i < 16; i++) load_coef(5'(i), 16'd0);
      load_coef(5'd16, 16'd5);
      run_check("signed", 5'd1, 9'd100, 40'hFF_C000_8000, -1);

      // Reset at tap 6.
      start = 1'b1;
      blk   = 5'd0;
      head  = 9'd15;
      @(negedge CLK);
      start = 1'b0;
      repeat (6) @(negedge CLK);
      check("mid_tap6_addr", 64'(mem_A), 64'({5'd0, 9'd9}));
      #2 reset = 1'b1;
      #1;
      check("mid_rst_flags", 64'({busy, y_valid, mem_CEN, mem_WEN}), 64'(4'b0011));
      check("mid_rst_y", 64'(y), 64'd0);
      check("mid_rst_addr", 64'(mem_A), 64'd0);
      @(negedge CLK);
      reset = 1'b0;
      seen  = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge CLK);
         if (y_valid || busy) seen++;
      end
      check("mid_no_valid", 64'(seen), 64'd0);

      run_check("zero_coef", 5'd0, 9'd15, 40'd0, -1);
      for (int i = 0; i < 16; i++) load_coef(5'(i), 16'(i + 1));
      run_check("reload", 5'd0, 9'd15, 40'd6800, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
